rc4_phase_sequencer: RTL and testbench

RC4_PHASE_SEQUENCER -- requirements
Module: rc4_phase_sequencer

---
 rtl/rc4_phase_sequencer_if.sv | 52 +++++
 rtl/rc4_phase_sequencer.sv | 110 +++++++++++
 tb/tb_rc4_phase_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_phase_sequencer_if.sv
// Bundle between the RC4 phase sequencer and its environment: run control,
// phase-engine handshakes, requester S-memory buses and the shared S-memory port.
interface rc4_phase_sequencer_if;
  logic       go;
  logic       abort;
  logic       init_start;
  logic       ksa_start;
  logic       prga_start;
  logic       init_finish;
  logic       ksa_finish;
  logic       prga_finish;
  logic [7:0] init_addr;
  logic [7:0] ksa_addr;
  logic [7:0] prga_addr;
  logic [7:0] init_data;
  logic [7:0] ksa_data;
  logic [7:0] prga_data;
  logic       init_wren;
  logic       ksa_wren;
  logic       prga_wren;
  logic [7:0] s_addr;
  logic [7:0] s_data;
  logic       s_wren;
  logic [1:0] grant;
  logic       busy;
  logic       done;
  logic       error;

  // Environment side: controller, phase engines and requesters.
  modport master (
    output go, abort,
    output init_finish, ksa_finish, prga_finish,
    output init_addr, ksa_addr, prga_addr,
    output init_data, ksa_data, prga_data,
    output init_wren, ksa_wren, prga_wren,
    input  init_start, ksa_start, prga_start,
    input  s_addr, s_data, s_wren,
    input  grant, busy, done, error
  );

  // Sequencer side.
  modport slave (
    input  go, abort,
    input  init_finish, ksa_finish, prga_finish,
    input  init_addr, ksa_addr, prga_addr,
    input  init_data, ksa_data, prga_data,
    input  init_wren, ksa_wren, prga_wren,
    output init_start, ksa_start, prga_start,
    output s_addr, s_data, s_wren,
    output grant, busy, done, error
  );
endinterface

// File: rtl/rc4_phase_sequencer.sv
// Runs the RC4 init -> KSA -> PRGA phase engines in order, handing the shared
// S-memory port to whichever phase currently owns it.
module rc4_phase_sequencer (
  input  logic                  clk,
  input  logic                  reset,
  rc4_phase_sequencer_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE,
    INIT_S, INIT_A, INIT_R,
    KSA_S,  KSA_A,  KSA_R,
    PRGA_S, PRGA_A, PRGA_R,
    DONE,
    ERROR
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] tmo_q, tmo_d;
  logic [1:0] grant_q, grant_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE:   if (bus.go) state_d = INIT_S;
      INIT_S: begin state_d = INIT_A; tmo_d = '0; end
      INIT_A: begin
        if (!bus.init_finish)     state_d = INIT_R;
        else if (tmo_q == 3'd3)   state_d = ERROR;
        else                      tmo_d = tmo_q + 3'd1;
      end
      INIT_R: if (bus.init_finish) state_d = KSA_S;
      KSA_S:  begin state_d = KSA_A; tmo_d = '0; end
      KSA_A: begin
        if (!bus.ksa_finish)      state_d = KSA_R;
        else if (tmo_q == 3'd3)   state_d = ERROR;
        else                      tmo_d = tmo_q + 3'd1;
      end
      KSA_R:  if (bus.ksa_finish) state_d = PRGA_S;
      PRGA_S: begin state_d = PRGA_A; tmo_d = '0; end
      PRGA_A: begin
        if (!bus.prga_finish)     state_d = PRGA_R;
        else if (tmo_q == 3'd3)   state_d = ERROR;
        else                      tmo_d = tmo_q + 3'd1;
      end
      PRGA_R: if (bus.prga_finish) state_d = DONE;
      DONE:   if (bus.go) state_d = INIT_S;
      ERROR:  state_d = ERROR;
      default: state_d = IDLE;
    endcase
    // Abort overrides every transition above, including any pending start.
    if (bus.abort) state_d = IDLE;
  end

  // Grant is derived from the next state so the register matches the phase of the state it enters.
  always_comb begin
    case (state_d)
      INIT_S, INIT_A, INIT_R: grant_d = 2'b01;
      KSA_S,  KSA_A,  KSA_R:  grant_d = 2'b10;
      PRGA_S, PRGA_A, PRGA_R: grant_d = 2'b11;
      default:                grant_d = 2'b00;
    endcase
  end

  assign bus.init_start = (state_q == INIT_S);
  assign bus.ksa_start  = (state_q == KSA_S);
  assign bus.prga_start = (state_q == PRGA_S);
  assign bus.grant      = grant_q;
  assign bus.busy       = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
  assign bus.done       = (state_q == DONE);
  assign bus.error      = (state_q == ERROR);

  always_comb begin
    bus.s_addr = '0;
    bus.s_data = '0;
    bus.s_wren = 1'b0;
    case (grant_q)
      2'b01: begin
        bus.s_addr = bus.init_addr;
        bus.s_data = bus.init_data;
        bus.s_wren = bus.init_wren;
      end
      2'b10: begin
        bus.s_addr = bus.ksa_addr;
        bus.s_data = bus.ksa_data;
        bus.s_wren = bus.ksa_wren;
      end
      2'b11: begin
        bus.s_addr = bus.prga_addr;
        bus.s_data = bus.prga_data;
        bus.s_wren = bus.prga_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Directed bench for rc4_phase_sequencer: a cycle-by-cycle vector table for the
// control FSM plus hand sequences for full runs, grant isolation, timeout, abort and reset.
module tb_rc4_phase_sequencer;

  logic clk = 1'b0;
  logic reset;
  rc4_phase_sequencer_if bus ();

  rc4_phase_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Observed control word: {prga_start, ksa_start, init_start, grant[1:0], busy, done, error}
  localparam logic [7:0] X_IDLE   = 8'b000_00_000;
  localparam logic [7:0] X_INIT_S = 8'b001_01_100;
  localparam logic [7:0] X_INIT   = 8'b000_01_100;
  localparam logic [7:0] X_KSA_S  = 8'b010_10_100;
  localparam logic [7:0] X_KSA    = 8'b000_10_100;
  localparam logic [7:0] X_PRGA_S = 8'b100_11_100;
  localparam logic [7:0] X_PRGA   = 8'b000_11_100;
  localparam logic [7:0] X_DONE   = 8'b000_00_010;
  localparam logic [7:0] X_ERR    = 8'b000_00_001;

  typedef struct {
    logic       rst_n;
    logic       go;
    logic       abort;
    logic [2:0] fin;   // {prga, ksa, init}
    logic [7:0] exp;
  } vec_t;

  localparam int NVEC = 33;
  vec_t vt [NVEC];

  // Finish pattern that walks IDLE->INIT_S through to DONE, one entry per cycle after go.
  logic [2:0] path [9];

  function automatic vec_t mk(input logic r, input logic g, input logic a,
                              input logic [2:0] f, input logic [7:0] e);
    vec_t v;
    v.rst_n = r; v.go = g; v.abort = a; v.fin = f; v.exp = e;
    return v;
  endfunction

  function automatic logic [7:0] obs();
    return {bus.prga_start, bus.ksa_start, bus.init_start, bus.grant,
            bus.busy, bus.done, bus.error};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic set_fin(input logic [2:0] f);
    bus.init_finish = f[0];
    bus.ksa_finish  = f[1];
    bus.prga_finish = f[2];
  endtask

  task automatic set_req(input logic [2:0] wren, input logic [7:0] base);
    bus.init_wren = wren[0];
    bus.ksa_wren  = wren[1];
    bus.prga_wren = wren[2];
    bus.init_addr = base + 8'h01; bus.init_data = base + 8'h11;
    bus.ksa_addr  = base + 8'h02; bus.ksa_data  = base + 8'h12;
    bus.prga_addr = base + 8'h03; bus.prga_data = base + 8'h13;
  endtask

  task automatic cyc(input logic g, input logic a, input logic [2:0] f);
    reset   = 1'b1;
    bus.go  = g;
    bus.abort = a;
    set_fin(f);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.go = 1'b0;
    bus.abort = 1'b0;
    set_fin(3'b111);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // go, then n steps along the canonical finish path (2:INIT_R 4:KSA_A 5:KSA_R 8:PRGA_R 9:DONE).
  task automatic advance(input int n);
    cyc(1'b1, 1'b0, 3'b111);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, path[i]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt [3];
    int pend [3];
    int run [3];
    int len [3];
    logic [2:0] f;
    logic [2:0] st;
    logic [1:0] last_g;
    int order_q [$];
    int grant_q [$];
    int n;
    logic seen;

    path[0] = 3'b111; path[1] = 3'b110; path[2] = 3'b111; path[3] = 3'b111;
    path[4] = 3'b101; path[5] = 3'b111; path[6] = 3'b111; path[7] = 3'b011;
    path[8] = 3'b111;

    vt[0]  = mk(0, 0, 0, 3'b111, X_IDLE);
    vt[1]  = mk(1, 0, 0, 3'b111, X_IDLE);
    vt[2]  = mk(1, 1, 0, 3'b111, X_INIT_S);
    vt[3]  = mk(1, 0, 0, 3'b111, X_INIT);
    vt[4]  = mk(1, 0, 0, 3'b110, X_INIT);
    vt[5]  = mk(1, 0, 0, 3'b110, X_INIT);
    vt[6]  = mk(1, 0, 0, 3'b111, X_KSA_S);
    vt[7]  = mk(1, 0, 0, 3'b111, X_KSA);
    vt[8]  = mk(1, 0, 0, 3'b101, X_KSA);
    vt[9]  = mk(1, 0, 0, 3'b111, X_PRGA_S);
    vt[10] = mk(1, 0, 0, 3'b111, X_PRGA);
    vt[11] = mk(1, 0, 0, 3'b011, X_PRGA);
    vt[12] = mk(1, 0, 0, 3'b111, X_DONE);
    vt[13] = mk(1, 0, 0, 3'b111, X_DONE);
    vt[14] = mk(1, 1, 1, 3'b111, X_IDLE);
    vt[15] = mk(1, 1, 0, 3'b111, X_INIT_S);
    vt[16] = mk(1, 0, 1, 3'b111, X_IDLE);
    vt[17] = mk(1, 1, 0, 3'b111, X_INIT_S);
    vt[18] = mk(1, 0, 0, 3'b111, X_INIT);
    vt[19] = mk(1, 0, 0, 3'b111, X_INIT);
    vt[20] = mk(1, 0, 0, 3'b111, X_INIT);
    vt[21] = mk(1, 0, 0, 3'b111, X_INIT);
    vt[22] = mk(1, 0, 0, 3'b111, X_ERR);
    vt[23] = mk(1, 1, 0, 3'b111, X_ERR);
    vt[24] = mk(1, 0, 1, 3'b111, X_IDLE);
    vt[25] = mk(0, 1, 0, 3'b111, X_IDLE);
    vt[26] = mk(1, 0, 0, 3'b111, X_IDLE);
    vt[27] = mk(1, 1, 0, 3'b111, X_INIT_S);
    vt[28] = mk(1, 0, 0, 3'b111, X_INIT);
    vt[29] = mk(1, 0, 0, 3'b111, X_INIT);
    vt[30] = mk(1, 0, 0, 3'b111, X_INIT);
    vt[31] = mk(1, 0, 0, 3'b110, X_INIT);
    vt[32] = mk(1, 0, 1, 3'b111, X_IDLE);

    set_req(3'b000, 8'h00);
    reset = 1'b0;
    bus.go = 1'b0;
    bus.abort = 1'b0;
    set_fin(3'b111);

    // Reset values of the shared port with all requesters idle
    @(posedge clk);
    #1;
    check("reset_s_wren", {31'd0, bus.s_wren}, 32'd0);
    check("reset_s_addr", {24'd0, bus.s_addr}, 32'd0);
    check("reset_s_data", {24'd0, bus.s_data}, 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      reset     = vt[i].rst_n;
      bus.go    = vt[i].go;
      bus.abort = vt[i].abort;
      set_fin(vt[i].fin);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {24'd0, obs()}, {24'd0, vt[i].exp});
    end

    // Full run with behavioural engines: ack one cycle after start, then run len cycles
    do_reset();
    len[0] = 256; len[1] = 768; len[2] = 20;
    for (int p = 0; p < 3; p++) begin cnt[p] = 0; pend[p] = 0; run[p] = 0; end
    f = 3'b111;
    last_g = 2'b00;
    cyc(1'b1, 1'b0, f);
    for (int c = 0; c < 3000; c++) begin
      st = {bus.prga_start, bus.ksa_start, bus.init_start};
      if (bus.grant != last_g) begin
        grant_q.push_back(int'(bus.grant));
        last_g = bus.grant;
      end
      if (bus.done) break;
      for (int p = 0; p < 3; p++) begin
        if (pend[p] != 0) begin
          f[p] = 1'b0; pend[p] = 0; run[p] = len[p];
        end else if (!f[p]) begin
          if (run[p] > 1) run[p]--;
          else f[p] = 1'b1;
        end
        if (st[p]) begin
          cnt[p]++;
          pend[p] = 1;
          order_q.push_back(p);
        end
      end
      cyc(1'b0, 1'b0, f);
    end
    check("full_done", {31'd0, bus.done}, 32'd1);
    check("full_error", {31'd0, bus.error}, 32'd0);
    check("full_init_starts", cnt[0], 1);
    check("full_ksa_starts", cnt[1], 1);
    check("full_prga_starts", cnt[2], 1);
    check("full_order_len", order_q.size(), 3);
    if (order_q.size() == 3) begin
      check("full_order0", order_q[0], 0);
      check("full_order1", order_q[1], 1);
      check("full_order2", order_q[2], 2);
    end
    check("full_grant_len", grant_q.size(), 4);
    if (grant_q.size() == 4) begin
      check("full_grant0", grant_q[0], 1);
      check("full_grant1", grant_q[1], 2);
      check("full_grant2", grant_q[2], 3);
      check("full_grant3", grant_q[3], 0);
    end

    // Grant isolation while KSA owns the port
    do_reset();
    advance(5);
    check("iso_grant", {30'd0, bus.grant}, 32'd2);
    set_req(3'b101, 8'h40);
    bus.ksa_addr = 8'h5A;
    #1;
    check("iso_wren_off", {31'd0, bus.s_wren}, 32'd0);
    check("iso_addr", {24'd0, bus.s_addr}, 32'h5A);
    bus.ksa_wren = 1'b1;
    bus.ksa_data = 8'hC3;
    #1;
    check("iso_wren_on", {31'd0, bus.s_wren}, 32'd1);
    check("iso_data", {24'd0, bus.s_data}, 32'hC3);
    cyc(1'b0, 1'b1, 3'b101);
    check("iso_idle_wren", {31'd0, bus.s_wren}, 32'd0);
    check("iso_idle_addr", {24'd0, bus.s_addr}, 32'd0);
    set_req(3'b000, 8'h00);

    // Ack timeout in KSA_A
    do_reset();
    advance(4);
    check("tmo_in_ksa_a", {24'd0, obs()}, {24'd0, X_KSA});
    set_req(3'b111, 8'h80);
    n = 0;
    for (int c = 1; c <= 8; c++) begin
      cyc(1'b0, 1'b0, 3'b111);
      if (bus.error) begin n = c; break; end
    end
    check("tmo_cycles", n, 4);
    check("tmo_state", {24'd0, obs()}, {24'd0, X_ERR});
    check("tmo_s_wren", {31'd0, bus.s_wren}, 32'd0);
    cyc(1'b1, 1'b0, 3'b111);
    check("tmo_go_ignored", {24'd0, obs()}, {24'd0, X_ERR});
    cyc(1'b0, 1'b1, 3'b111);
    check("tmo_abort", {24'd0, obs()}, {24'd0, X_IDLE});
    set_req(3'b000, 8'h00);

    // Abort in INIT_R coinciding with init_finish rising
    do_reset();
    advance(2);
    check("abt_in_init_r", {24'd0, obs()}, {24'd0, X_INIT});
    cyc(1'b0, 1'b1, 3'b111);
    check("abt_idle", {24'd0, obs()}, {24'd0, X_IDLE});
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc(1'b0, 1'b0, 3'b111);
      seen = seen | bus.ksa_start;
    end
    check("abt_no_ksa_start", {31'd0, seen}, 32'd0);

    // Restart from DONE
    do_reset();
    advance(9);
    check("rst_done", {24'd0, obs()}, {24'd0, X_DONE});
    cyc(1'b1, 1'b0, 3'b111);
    check("restart_init_s", {24'd0, obs()}, {24'd0, X_INIT_S});
    cyc(1'b0, 1'b0, 3'b111);
    check("restart_pulse_end", {24'd0, obs()}, {24'd0, X_INIT});
    cyc(1'b0, 1'b1, 3'b111);

    // Synchronous reset during PRGA_R, with prga_finish rising on the same edge
    do_reset();
    advance(8);
    check("rst_in_prga_r", {24'd0, obs()}, {24'd0, X_PRGA});
    set_req(3'b111, 8'hA0);
    reset = 1'b0;
    bus.go = 1'b1;
    bus.abort = 1'b1;
    set_fin(3'b111);
    @(posedge clk);
    #1;
    check("rst_mid_ctrl", {24'd0, obs()}, {24'd0, X_IDLE});
    check("rst_mid_wren", {31'd0, bus.s_wren}, 32'd0);
    check("rst_mid_addr", {24'd0, bus.s_addr}, 32'd0);
    check("rst_mid_data", {24'd0, bus.s_data}, 32'd0);
    cyc(1'b1, 1'b0, 3'b111);
    check("rst_then_go", {24'd0, obs()}, {24'd0, X_INIT_S});
    check("rst_then_go_addr", {24'd0, bus.s_addr}, 32'hA1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
